sigmoid_result_fifo: RTL and testbench
======================================

// Module: sigmoid_result_fifo
// PURPOSE
//  Downstream stage of the sigmoid unit. Captures each valid sigmoid result into a
//  small FIFO and re-presents it to the consumer with a valid/ready handshake.
//  The sigmoid unit has no backpressure, so results that arrive while the FIFO is
//  full are dropped and flagged.
//  Only o_y[14:8] of the sigmoid result carries information, so storage is 7 bits/entry.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of two, >= 2
//  AW     2  pointer width, log2(DEPTH)
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous, active-high reset
//  i_in_valid  in   1       sigmoid result valid (sigmoid o_out_valid)
//  i_y         in   16      sigmoid result (sigmoid o_y)
//  i_ready     in   1       consumer ready to take head entry
//  o_valid     out  1       head entry available
//  o_y         out  16      head entry, re-expanded to 16 bits
//  o_count     out  AW+1    entries currently held, 0..DEPTH
//  o_overflow  out  1       sticky flag: one or more results were dropped
//  number      out  51      transistor count, summed over all instantiated cells
// BEHAVIOUR
//  - Reset (async, immediate):
//    - o_valid=0, o_y=16'h0000, o_count=0, o_overflow=0.
//    - Read/write pointers=0; stored contents are discarded.
//    - Reset asserted mid-operation drops everything in flight; no partial pops.
//  - Push: i_in_valid=1 and (count<DEPTH, or a pop happens in the same cycle).
//    - Writes i_y[14:8] at the tail. i_y[15] and i_y[7:0] are ignored and not stored.
//  - Pop: o_valid=1 and i_ready=1 at a rising edge. Head advances.
//  - o_valid = (count!=0). There is no bypass: a push into an empty FIFO is visible
//    one cycle later, so push-to-o_valid latency is 1 clock.
//  - o_y = {1'b0, head[6:0], 8'h00} when o_valid=1. Otherwise o_y=16'h0000.
//  - o_y and o_valid must stay stable while o_valid=1 and i_ready=0.
//  - Count update:
//    - +1 on push only.
//    - -1 on pop only.
//    - Unchanged on push+pop, and on neither.
//  - Full (count=DEPTH):
//    - Push without pop: the sample is dropped, o_overflow<=1, contents unchanged.
//    - Push with pop: the push is accepted, count stays DEPTH, and the new sample
//      lands at the tail.
//  - Empty (count=0): i_ready is ignored. Push+ready in the same cycle leaves count=1.
//  - Pointers wrap modulo DEPTH. Count never exceeds DEPTH and never goes below 0.
//  - o_overflow clears only on rst.
//  - Built from codebase cells (FD2-based registers, MUX21H, gates). Every cell
//    reports its transistor count, and number is the sum of those reports.
//  - number is a constant after elaboration and must be independent of data.
// TESTING
//  1. Reset, push 16'h3F00/16'h4000/16'h7F00 on consecutive cycles with i_ready=0
//     -> o_valid rises 1 cycle after the first push, o_y=16'h3F00, o_count=3.
//  2. Fill 4 entries with i_ready=0, then push 16'h1100
//     -> o_overflow=1, o_count=4, and the drain returns the original 4 in order.
//  3. Full FIFO, push 16'h2A00 with i_ready=1 in the same cycle
//     -> o_count stays 4, head advances, and 16'h2A00 emerges 4th.
//  4. Empty FIFO, i_ready=1, push 16'h5500
//     -> no pop that cycle; next cycle o_valid=1, o_y=16'h5500, o_count=1.
//  5. Push 16'hFFFF -> o_y=16'h7F00 (bits 15 and 7:0 forced to 0).
//  6. o_count=3, assert rst mid-cycle
//     -> o_valid/o_count/o_overflow go to 0 before the next edge.
//     After release, the FIFO refills correctly from pointer 0.

Source files
------------

// File: rtl/sigmoid_result_fifo.sv
// sigmoid_result_fifo: captures valid sigmoid results (bits 14:8 only) into a
// small FIFO built from library cells and re-presents them to a consumer.
// Handshake: the head entry is offered while o_valid=1; it is consumed at a
// rising edge where o_valid=1 and i_ready=1. o_valid/o_y hold while i_ready=0.
// Every cell reports its transistor count; number is the sum over all cells.

module inv (
   input  logic        a,
   output logic        z,
   output logic [50:0] number
);
   assign z      = ~a;
   assign number = 51'd2;
endmodule

module and2 (
   input  logic        a,
   input  logic        b,
   output logic        z,
   output logic [50:0] number
);
   assign z      = a & b;
   assign number = 51'd6;
endmodule

module or2 (
   input  logic        a,
   input  logic        b,
   output logic        z,
   output logic [50:0] number
);
   assign z      = a | b;
   assign number = 51'd6;
endmodule

module xor2 (
   input  logic        a,
   input  logic        b,
   output logic        z,
   output logic [50:0] number
);
   assign z      = a ^ b;
   assign number = 51'd12;
endmodule

module mux21h (
   input  logic        a0,
   input  logic        a1,
   input  logic        s,
   output logic        z,
   output logic [50:0] number
);
   assign z      = s ? a1 : a0;
   assign number = 51'd12;
endmodule

module fa1 (
   input  logic        a,
   input  logic        b,
   input  logic        ci,
   output logic        s,
   output logic        co,
   output logic [50:0] number
);
   assign s      = a ^ b ^ ci;
   assign co     = (a & b) | (ci & (a ^ b));
   assign number = 51'd28;
endmodule

module fd2 (
   input  logic        cp,
   input  logic        clr,
   input  logic        d,
   output logic        q,
   output logic [50:0] number
);
   // D flip-flop with asynchronous active-high clear
   always_ff @(posedge cp or posedge clr) begin
      if (clr) q <= 1'b0;
      else     q <= d;
   end
   assign number = 51'd26;
endmodule

// Pointer register that increments (mod 2^AW) when en=1, via a ripple half-adder chain
module ptr_reg #(
   parameter int AW = 2
) (
   input  logic          cp,
   input  logic          clr,
   input  logic          en,
   output logic [AW-1:0] q,
   output logic [50:0]   number
);
   logic [AW-1:0] d;
   logic          c [AW];
   logic [50:0]   tc_x [AW];
   logic [50:0]   tc_f [AW];
   logic [50:0]   tc_a [AW];

   assign c[0] = en;

   for (genvar i = 0; i < AW; i++) begin : g_bit
      xor2 u_x (.a(q[i]), .b(c[i]), .z(d[i]), .number(tc_x[i]));
      fd2  u_f (.cp(cp), .clr(clr), .d(d[i]), .q(q[i]), .number(tc_f[i]));
      if (i < AW - 1) begin : g_cy
         and2 u_a (.a(q[i]), .b(c[i]), .z(c[i+1]), .number(tc_a[i]));
      end else begin : g_nocy
         assign tc_a[i] = '0;
      end
   end

   // Transistor total of this pointer
   always_comb begin
      number = '0;
      for (int i = 0; i < AW; i++) number = number + tc_x[i] + tc_f[i] + tc_a[i];
   end
endmodule

module sigmoid_result_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_in_valid,
   input  logic [15:0] i_y,
   input  logic        i_ready,
   output logic        o_valid,
   output logic [15:0] o_y,
   output logic [AW:0] o_count,
   output logic        o_overflow,
   output logic [50:0] number
);
   localparam int W = 7;

   logic [W-1:0]  din;
   logic          unused_y_bits;
   logic          pop, nfull, room, push_ok, npop, npush, inc, dec, delta_lo, drop;
   logic          ovf_q, ovf_d, valid;
   logic [AW-1:0] wptr_q, wptr_n, rptr_q;
   logic [AW:0]   cnt_q, cnt_d, delta;
   logic          cy [AW+1];
   logic          msb_x;
   logic          vor [AW+1];
   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic          we_c [DEPTH][AW+1];
   logic [W-1:0]  tree [2*DEPTH-1];

   logic [50:0] tc_pop, tc_nfull, tc_room, tc_push, tc_npop, tc_npush;
   logic [50:0] tc_inc, tc_dec, tc_dlo, tc_drop, tc_ovfo, tc_ovff;
   logic [50:0] tc_wptr, tc_rptr, tc_mx0, tc_mx1;
   logic [50:0] tc_winv [AW];
   logic [50:0] tc_we   [DEPTH][AW];
   logic [50:0] tc_mff  [DEPTH][W];
   logic [50:0] tc_mmx  [DEPTH][W];
   logic [50:0] tc_tree [DEPTH-1][W];
   logic [50:0] tc_out  [W];
   logic [50:0] tc_vor  [AW];
   logic [50:0] tc_cff  [AW+1];
   logic [50:0] tc_fa   [AW];

   assign din           = i_y[14:8];
   assign unused_y_bits = &{1'b0, i_y[15], i_y[7:0]};

   // Handshake control: pop when head offered and taken; push when room or popping
   and2 u_pop   (.a(valid),      .b(i_ready),  .z(pop),      .number(tc_pop));
   inv  u_nfull (.a(cnt_q[AW]),                .z(nfull),    .number(tc_nfull));
   or2  u_room  (.a(nfull),      .b(pop),      .z(room),     .number(tc_room));
   and2 u_push  (.a(i_in_valid), .b(room),     .z(push_ok),  .number(tc_push));
   inv  u_npop  (.a(pop),                      .z(npop),     .number(tc_npop));
   inv  u_npush (.a(push_ok),                  .z(npush),    .number(tc_npush));
   and2 u_inc   (.a(push_ok),    .b(npop),     .z(inc),      .number(tc_inc));
   and2 u_dec   (.a(pop),        .b(npush),    .z(dec),      .number(tc_dec));
   or2  u_dlo   (.a(inc),        .b(dec),      .z(delta_lo), .number(tc_dlo));

   // Sticky overflow: a valid sample that could not be pushed
   and2 u_drop  (.a(i_in_valid), .b(npush),    .z(drop),     .number(tc_drop));
   or2  u_ovfo  (.a(ovf_q),      .b(drop),     .z(ovf_d),    .number(tc_ovfo));
   fd2  u_ovff  (.cp(clk), .clr(rst), .d(ovf_d), .q(ovf_q),   .number(tc_ovff));

   // Pointers
   ptr_reg #(.AW(AW)) u_wptr (.cp(clk), .clr(rst), .en(push_ok), .q(wptr_q), .number(tc_wptr));
   ptr_reg #(.AW(AW)) u_rptr (.cp(clk), .clr(rst), .en(pop),     .q(rptr_q), .number(tc_rptr));

   // Storage with per-entry write enable decoded from the write pointer
   for (genvar b = 0; b < AW; b++) begin : g_winv
      inv u_i (.a(wptr_q[b]), .z(wptr_n[b]), .number(tc_winv[b]));
   end

   for (genvar e = 0; e < DEPTH; e++) begin : g_ent
      assign we_c[e][0] = push_ok;
      for (genvar b = 0; b < AW; b++) begin : g_dec
         and2 u_a (.a(we_c[e][b]), .b((((e >> b) & 1) == 1) ? wptr_q[b] : wptr_n[b]),
                   .z(we_c[e][b+1]), .number(tc_we[e][b]));
      end
      for (genvar j = 0; j < W; j++) begin : g_bit
         mux21h u_m (.a0(mem_q[e][j]), .a1(din[j]), .s(we_c[e][AW]),
                     .z(mem_d[e][j]), .number(tc_mmx[e][j]));
         fd2    u_f (.cp(clk), .clr(rst), .d(mem_d[e][j]), .q(mem_q[e][j]),
                     .number(tc_mff[e][j]));
      end
      assign tree[DEPTH-1+e] = mem_q[e];
   end

   // Head read: binary mux tree, root selects on the pointer MSB
   for (genvar d = 0; d < AW; d++) begin : g_lvl
      for (genvar k = 0; k < (1 << d); k++) begin : g_node
         localparam int I = (1 << d) - 1 + k;
         for (genvar j = 0; j < W; j++) begin : g_bit
            mux21h u_m (.a0(tree[2*I+1][j]), .a1(tree[2*I+2][j]), .s(rptr_q[AW-1-d]),
                        .z(tree[I][j]), .number(tc_tree[I][j]));
         end
      end
   end

   // Output: head re-expanded, forced to zero while empty
   for (genvar j = 0; j < W; j++) begin : g_out
      and2 u_a (.a(tree[0][j]), .b(valid), .z(o_y[8+j]), .number(tc_out[j]));
   end
   assign o_y[15]  = 1'b0;
   assign o_y[7:0] = 8'h00;

   // Count: add +1, -1 (all ones) or 0
   assign delta = {{AW{dec}}, delta_lo};
   assign cy[0] = 1'b0;
   for (genvar i = 0; i < AW; i++) begin : g_cnt
      fa1 u_fa (.a(cnt_q[i]), .b(delta[i]), .ci(cy[i]), .s(cnt_d[i]), .co(cy[i+1]),
                .number(tc_fa[i]));
   end
   xor2 u_mx0 (.a(cnt_q[AW]), .b(delta[AW]), .z(msb_x),      .number(tc_mx0));
   xor2 u_mx1 (.a(msb_x),     .b(cy[AW]),    .z(cnt_d[AW]),  .number(tc_mx1));
   for (genvar i = 0; i <= AW; i++) begin : g_cff
      fd2 u_f (.cp(clk), .clr(rst), .d(cnt_d[i]), .q(cnt_q[i]), .number(tc_cff[i]));
   end

   // Valid: OR-reduce of the count
   assign vor[0] = cnt_q[0];
   for (genvar i = 0; i < AW; i++) begin : g_vor
      or2 u_o (.a(vor[i]), .b(cnt_q[i+1]), .z(vor[i+1]), .number(tc_vor[i]));
   end
   assign valid = vor[AW];

   assign o_valid    = valid;
   assign o_count    = cnt_q;
   assign o_overflow = ovf_q;

   // Transistor total over every instantiated cell
   always_comb begin
      number = tc_pop + tc_nfull + tc_room + tc_push + tc_npop + tc_npush + tc_inc
             + tc_dec + tc_dlo + tc_drop + tc_ovfo + tc_ovff + tc_wptr + tc_rptr
             + tc_mx0 + tc_mx1;
      for (int b = 0; b < AW; b++) number = number + tc_winv[b] + tc_vor[b] + tc_fa[b];
      for (int i = 0; i <= AW; i++) number = number + tc_cff[i];
      for (int j = 0; j < W; j++) number = number + tc_out[j];
      for (int e = 0; e < DEPTH; e++) begin
         for (int b = 0; b < AW; b++) number = number + tc_we[e][b];
         for (int j = 0; j < W; j++) number = number + tc_mff[e][j] + tc_mmx[e][j];
      end
      for (int n = 0; n < DEPTH - 1; n++)
         for (int j = 0; j < W; j++) number = number + tc_tree[n][j];
   end
endmodule

// File: tb/tb_sigmoid_result_fifo.sv
// Bench for sigmoid_result_fifo: table of {inputs, expected post-edge outputs}
// plus hand-written sequences for no-bypass and mid-cycle async reset.
module tb_sigmoid_result_fifo;
   logic        clk;
   logic        rst;
   logic        i_in_valid;
   logic [15:0] i_y;
   logic        i_ready;
   logic        o_valid;
   logic [15:0] o_y;
   logic [2:0]  o_count;
   logic        o_overflow;
   logic [50:0] number;

   // Cell inventory for DEPTH=4: 36 fd2, 49 mux21h, 5 inv, 22 and2, 5 or2, 6 xor2, 2 fa1
   localparam logic [50:0] EXP_NUMBER = 51'd1824;

   typedef struct {
      logic        iv;
      logic [15:0] y;
      logic        rdy;
      logic        ev;
      logic [15:0] ey;
      logic [2:0]  ec;
      logic        eo;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   sigmoid_result_fifo #(.DEPTH(4), .AW(2)) dut (
      .clk(clk), .rst(rst), .i_in_valid(i_in_valid), .i_y(i_y), .i_ready(i_ready),
      .o_valid(o_valid), .o_y(o_y), .o_count(o_count), .o_overflow(o_overflow),
      .number(number)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [50:0] act, input logic [50:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic add(input logic iv, input logic [15:0] y, input logic rdy,
                      input logic ev, input logic [15:0] ey, input int ec, input logic eo);
      vec_t v;
      v.iv = iv; v.y = y; v.rdy = rdy; v.ev = ev; v.ey = ey; v.ec = ec[2:0]; v.eo = eo;
      vecs.push_back(v);
   endtask

   task automatic check_state(input string tag, input logic ev, input logic [15:0] ey,
                              input logic [2:0] ec, input logic eo);
      check({tag, " valid"},    {50'd0, o_valid},    {50'd0, ev});
      check({tag, " y"},        {35'd0, o_y},        {35'd0, ey});
      check({tag, " count"},    {48'd0, o_count},    {48'd0, ec});
      check({tag, " overflow"}, {50'd0, o_overflow}, {50'd0, eo});
   endtask

   // Drive a vector, clock it, check outputs 1 time unit after the edge
   task automatic apply(input vec_t v, input string tag);
      i_in_valid = v.iv;
      i_y        = v.y;
      i_ready    = v.rdy;
      @(posedge clk);
      #1;
      check_state(tag, v.ev, v.ey, v.ec, v.eo);
   endtask

   initial begin
      rst        = 1'b1;
      i_in_valid = 1'b0;
      i_y        = 16'h0000;
      i_ready    = 1'b0;

      // iv, y, rdy | valid, y, count, overflow
      // 1: three pushes with consumer stalled
      add(1, 16'h3F00, 0,  1, 16'h3F00, 1, 0);
      add(1, 16'h4000, 0,  1, 16'h3F00, 2, 0);
      add(1, 16'h7F00, 0,  1, 16'h3F00, 3, 0);
      // 2: fill, then a dropped push, hold, drain in order
      add(1, 16'h1200, 0,  1, 16'h3F00, 4, 0);
      add(1, 16'h1100, 0,  1, 16'h3F00, 4, 1);
      add(0, 16'h0000, 0,  1, 16'h3F00, 4, 1);
      add(0, 16'h0000, 1,  1, 16'h4000, 3, 1);
      add(0, 16'h0000, 1,  1, 16'h7F00, 2, 1);
      add(0, 16'h0000, 1,  1, 16'h1200, 1, 1);
      add(0, 16'h0000, 1,  0, 16'h0000, 0, 1);
      add(0, 16'h0000, 1,  0, 16'h0000, 0, 1);
      // 3: full FIFO with simultaneous push and pop
      add(1, 16'h0100, 0,  1, 16'h0100, 1, 1);
      add(1, 16'h0200, 0,  1, 16'h0100, 2, 1);
      add(1, 16'h0300, 0,  1, 16'h0100, 3, 1);
      add(1, 16'h0400, 0,  1, 16'h0100, 4, 1);
      add(1, 16'h2A00, 1,  1, 16'h0200, 4, 1);
      add(0, 16'h0000, 1,  1, 16'h0300, 3, 1);
      add(0, 16'h0000, 1,  1, 16'h0400, 2, 1);
      add(0, 16'h0000, 1,  1, 16'h2A00, 1, 1);
      add(0, 16'h0000, 1,  0, 16'h0000, 0, 1);
      // 4: empty, push with ready high
      add(1, 16'h5500, 1,  1, 16'h5500, 1, 1);
      add(0, 16'h0000, 1,  0, 16'h0000, 0, 1);
      // 5: ignored bits, push+pop while not full
      add(1, 16'hFFFF, 0,  1, 16'h7F00, 1, 1);
      add(1, 16'h80FF, 0,  1, 16'h7F00, 2, 1);
      add(0, 16'h0000, 1,  1, 16'h0000, 1, 1);
      add(1, 16'h2B00, 1,  1, 16'h2B00, 1, 1);
      add(0, 16'h0000, 1,  0, 16'h0000, 0, 1);
      // 6 (pre-reset): three entries pending
      add(1, 16'h0A00, 0,  1, 16'h0A00, 1, 1);
      add(1, 16'h0B00, 0,  1, 16'h0A00, 2, 1);
      add(1, 16'h0C00, 0,  1, 16'h0A00, 3, 1);

      #12 rst = 1'b0;
      check_state("reset", 1'b0, 16'h0000, 3'd0, 1'b0);
      check("number", number, EXP_NUMBER);

      // No bypass: a push presented to an empty FIFO is not visible before the edge
      i_in_valid = 1'b1;
      i_y        = 16'h3F00;
      #1;
      check("nobypass valid", {50'd0, o_valid}, 51'd0);
      check("nobypass y", {35'd0, o_y}, 51'd0);

      foreach (vecs[k]) apply(vecs[k], $sformatf("vec%0d", k));

      // Mid-cycle async reset with count=3 and overflow set
      i_in_valid = 1'b0;
      i_ready    = 1'b0;
      #3 rst = 1'b1;
      #1;
      check_state("midrst", 1'b0, 16'h0000, 3'd0, 1'b0);
      #2 rst = 1'b0;

      // Refill after reset from pointer 0
      vecs.delete();
      add(1, 16'h6600, 0,  1, 16'h6600, 1, 0);
      add(1, 16'h6700, 0,  1, 16'h6600, 2, 0);
      add(0, 16'h0000, 1,  1, 16'h6700, 1, 0);
      add(0, 16'h0000, 1,  0, 16'h0000, 0, 0);
      foreach (vecs[k]) apply(vecs[k], $sformatf("refill%0d", k));

      check("number stable", number, EXP_NUMBER);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
